tvs_reader: RTL and testbench

TVS_READER -- requirements
Module: tvs_reader

---
 rtl/tvs_pkg.sv | 29 ++
 rtl/tvs_sync.sv | 28 ++
 rtl/tvs_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_tvs_reader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tvs_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tvs_pkg : shared channel, read-select and clear-FSM definitions
// Revision: 1.0
// ------------------------------------------------------------------
package tvs_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_1V0  = 2'd0;
    localparam logic [1:0] CH_1V8  = 2'd1;
    localparam logic [1:0] CH_2V5  = 2'd2;
    localparam logic [1:0] CH_TEMP = 2'd3;

    localparam logic [1:0] SEL_LAST  = 2'd0;
    localparam logic [1:0] SEL_MIN   = 2'd1;
    localparam logic [1:0] SEL_MAX   = 2'd2;
    localparam logic [1:0] SEL_COUNT = 2'd3;

    localparam int SETTLE_CYCLES = 3;

    typedef enum logic [1:0] {
        CLR_IDLE   = 2'd0,
        CLR_PULSE  = 2'd1,
        CLR_SETTLE = 2'd2
    } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/tvs_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// tvs_sync : two-flop synchronizer for asynchronous sensor status
// Revision: 1.0
// ------------------------------------------------------------------
module tvs_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tvs_reader.sv
`default_nettype none
// ------------------------------------------------------------------
// tvs_reader : TVS sensor capture, min/max/count statistics, alarms
// Revision: 1.0
// ------------------------------------------------------------------
module tvs_reader
    import tvs_pkg::*;
#(
    parameter int CLR_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] tvs_value,
    input  logic [1:0]  tvs_channel,
    input  logic        tvs_valid,
    input  logic        tvs_active,
    input  logic        tvs_temp_high,
    input  logic        tvs_temp_low,
    output logic [3:0]  tvs_enable,
    output logic        tvs_temp_high_clear,
    output logic        tvs_temp_low_clear,
    input  logic [3:0]  enable_mask,
    input  logic        minmax_clr,
    input  logic        alarm_clr,
    input  logic        rd_req,
    input  logic [1:0]  rd_ch,
    input  logic [1:0]  rd_sel,
    output logic        rd_ack,
    output logic [15:0] rd_data,
    output logic        alarm_high,
    output logic        alarm_low,
    output logic        stale,
    output logic        sensor_active
);

    localparam int CNT_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX   = TW'(TIMEOUT_CYCLES - 1);

    logic valid_s, temp_high_s, temp_low_s;
    logic valid_d;
    logic capture;

    tvs_sync #(.WIDTH(1)) u_sync_valid  (.clk(clk), .reset_n(reset_n), .d(tvs_valid),     .q(valid_s));
    tvs_sync #(.WIDTH(1)) u_sync_active (.clk(clk), .reset_n(reset_n), .d(tvs_active),    .q(sensor_active));
    tvs_sync #(.WIDTH(1)) u_sync_thigh  (.clk(clk), .reset_n(reset_n), .d(tvs_temp_high), .q(temp_high_s));
    tvs_sync #(.WIDTH(1)) u_sync_tlow   (.clk(clk), .reset_n(reset_n), .d(tvs_temp_low),  .q(temp_low_s));

    assign capture = valid_s & ~valid_d;

    logic [15:0] last_val [NUM_CH];
    logic [15:0] min_val  [NUM_CH];
    logic [15:0] max_val  [NUM_CH];
    logic [15:0] count    [NUM_CH];
    logic [NUM_CH-1:0] seen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_d    <= 1'b0;
            tvs_enable <= '0;
        end else begin
            valid_d    <= valid_s;
            tvs_enable <= enable_mask;
        end
    end

    // A coincident clear is written first so the capture below overrides it
    // on its own channel and lands as a first sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                last_val[i] <= '0;
                min_val[i]  <= 16'hFFFF;
                max_val[i]  <= '0;
                count[i]    <= '0;
            end
            seen <= '0;
        end else begin
            if (minmax_clr) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    min_val[i] <= 16'hFFFF;
                    max_val[i] <= '0;
                    count[i]   <= '0;
                end
                seen <= '0;
            end
            if (capture && enable_mask[tvs_channel]) begin
                last_val[tvs_channel] <= tvs_value;
                if (minmax_clr || !seen[tvs_channel]) begin
                    min_val[tvs_channel] <= tvs_value;
                    max_val[tvs_channel] <= tvs_value;
                    count[tvs_channel]   <= 16'd1;
                    seen[tvs_channel]    <= 1'b1;
                end else begin
                    if (tvs_value < min_val[tvs_channel])
                        min_val[tvs_channel] <= tvs_value;
                    if (tvs_value > max_val[tvs_channel])
                        max_val[tvs_channel] <= tvs_value;
                    if (count[tvs_channel] != 16'hFFFF)
                        count[tvs_channel] <= count[tvs_channel] + 16'd1;
                end
            end
        end
    end

    logic [15:0] rd_field;

    always_comb begin
        rd_field = '0;
        case (rd_sel)
            SEL_LAST:  rd_field = last_val[rd_ch];
            SEL_MIN:   rd_field = min_val[rd_ch];
            SEL_MAX:   rd_field = max_val[rd_ch];
            SEL_COUNT: rd_field = count[rd_ch];
            default:   rd_field = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req)
                rd_data <= rd_field;
        end
    end

    clr_state_t    state, state_nxt;
    logic [CW-1:0] clr_cnt, clr_cnt_nxt;
    logic          alarm_wipe;
    logic          clear_pulse;

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        alarm_wipe  = 1'b0;
        case (state)
            CLR_IDLE: begin
                if (alarm_clr) begin
                    state_nxt   = CLR_PULSE;
                    clr_cnt_nxt = '0;
                    alarm_wipe  = 1'b1;
                end
            end
            CLR_PULSE: begin
                if (clr_cnt == PULSE_LAST) begin
                    state_nxt   = CLR_SETTLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + CW'(1);
                end
            end
            CLR_SETTLE: begin
                if (clr_cnt == SETTLE_LAST) begin
                    state_nxt   = CLR_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt   = CLR_IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Clear outputs come straight from a flop so the sensor never sees decode glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= CLR_IDLE;
            clr_cnt     <= '0;
            clear_pulse <= 1'b0;
            alarm_high  <= 1'b0;
            alarm_low   <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_cnt     <= clr_cnt_nxt;
            clear_pulse <= (state_nxt == CLR_PULSE);
            if (alarm_wipe) begin
                alarm_high <= 1'b0;
                alarm_low  <= 1'b0;
            end else if (state == CLR_IDLE) begin
                alarm_high <= alarm_high | temp_high_s;
                alarm_low  <= alarm_low  | temp_low_s;
            end
        end
    end

    assign tvs_temp_high_clear = clear_pulse;
    assign tvs_temp_low_clear  = clear_pulse;

    logic [TW-1:0] timer, timer_nxt;

    always_comb begin
        timer_nxt = timer;
        if (capture || (enable_mask == 4'd0))
            timer_nxt = '0;
        else if (timer != TIMER_MAX)
            timer_nxt = timer + TW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
            stale <= 1'b0;
        end else begin
            timer <= timer_nxt;
            stale <= (timer_nxt == TIMER_MAX);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tvs_reader.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tvs_reader : randomized self-checking bench with statistics model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_tvs_reader;

    localparam int CLR_CYC = 4;
    localparam int TMO     = 16;

    logic        clk;
    logic        reset_n;
    logic [15:0] tvs_value;
    logic [1:0]  tvs_channel;
    logic        tvs_valid, tvs_active, tvs_temp_high, tvs_temp_low;
    logic [3:0]  tvs_enable;
    logic        tvs_temp_high_clear, tvs_temp_low_clear;
    logic [3:0]  enable_mask;
    logic        minmax_clr, alarm_clr;
    logic        rd_req;
    logic [1:0]  rd_ch, rd_sel;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        alarm_high, alarm_low, stale, sensor_active;

    tvs_reader #(.CLR_CYCLES(CLR_CYC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .tvs_value(tvs_value), .tvs_channel(tvs_channel),
        .tvs_valid(tvs_valid), .tvs_active(tvs_active),
        .tvs_temp_high(tvs_temp_high), .tvs_temp_low(tvs_temp_low),
        .tvs_enable(tvs_enable),
        .tvs_temp_high_clear(tvs_temp_high_clear), .tvs_temp_low_clear(tvs_temp_low_clear),
        .enable_mask(enable_mask), .minmax_clr(minmax_clr), .alarm_clr(alarm_clr),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_ack(rd_ack), .rd_data(rd_data),
        .alarm_high(alarm_high), .alarm_low(alarm_low),
        .stale(stale), .sensor_active(sensor_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference statistics per channel
    int m_last [4];
    int m_min  [4];
    int m_max  [4];
    int m_cnt  [4];
    bit m_seen [4];

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_last[i] = 0; m_min[i] = 'hFFFF; m_max[i] = 0; m_cnt[i] = 0; m_seen[i] = 0;
        end
    endtask

    task automatic m_apply(input int ch, input int val, input bit en, input bit clr);
        if (clr)
            for (int i = 0; i < 4; i++) begin
                m_min[i] = 'hFFFF; m_max[i] = 0; m_cnt[i] = 0; m_seen[i] = 0;
            end
        if (en) begin
            m_last[ch] = val;
            if (!m_seen[ch]) begin
                m_min[ch] = val; m_max[ch] = val; m_seen[ch] = 1;
            end else begin
                if (val < m_min[ch]) m_min[ch] = val;
                if (val > m_max[ch]) m_max[ch] = val;
            end
            if (m_cnt[ch] < 'hFFFF) m_cnt[ch] = m_cnt[ch] + 1;
        end
    endtask

    function automatic logic [31:0] m_field(input int ch, input int sel);
        case (sel)
            0:       return 32'(m_last[ch]);
            1:       return 32'(m_min[ch]);
            2:       return 32'(m_max[ch]);
            default: return 32'(m_cnt[ch]);
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_ack"}, 32'(rd_ack), 0);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_alarm_high"}, 32'(alarm_high), 0);
        chk({tag, "_alarm_low"}, 32'(alarm_low), 0);
        chk({tag, "_stale"}, 32'(stale), 0);
        chk({tag, "_tvs_enable"}, 32'(tvs_enable), 0);
        chk({tag, "_clear_h"}, 32'(tvs_temp_high_clear), 0);
        chk({tag, "_clear_l"}, 32'(tvs_temp_low_clear), 0);
        chk({tag, "_sensor_active"}, 32'(sensor_active), 0);
    endtask

    task automatic set_mask(input logic [3:0] m);
        @(negedge clk);
        enable_mask = m;
        @(negedge clk);
        chk("tvs_enable", 32'(tvs_enable), 32'(m));
    endtask

    task automatic read_check(input string tag, input int ch, input int sel, input logic [31:0] exp);
        @(negedge clk);
        rd_req = 1'b1; rd_ch = 2'(ch); rd_sel = 2'(sel);
        @(negedge clk);
        rd_req = 1'b0;
        chk({tag, "_ack"}, 32'(rd_ack), 1);
        chk(tag, 32'(rd_data), exp);
        @(negedge clk);
        chk({tag, "_ack_single"}, 32'(rd_ack), 0);
    endtask

    // Returns three clock edges after the capture edge.
    task automatic pulse(input int ch, input int val, input bit clr, input bit rd, input int sel);
        logic [31:0] exp_rd;
        exp_rd = 0;
        @(negedge clk);
        tvs_channel = 2'(ch); tvs_value = 16'(val); tvs_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        minmax_clr = clr;
        if (rd) begin
            rd_req = 1'b1; rd_ch = 2'(ch); rd_sel = 2'(sel);
            exp_rd = m_field(ch, sel);
        end
        @(negedge clk);
        minmax_clr = 1'b0; rd_req = 1'b0;
        if (rd) begin
            chk("coinc_ack", 32'(rd_ack), 1);
            chk("coinc_data", 32'(rd_data), exp_rd);
        end
        m_apply(ch, val, enable_mask[ch], clr);
        tvs_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic clr_h [12];
    logic clr_l [12];
    logic alm   [12];

    initial begin
        int ch, val, sel, rch, rsel;
        bit clr, rd;

        reset_n = 1'b0;
        tvs_value = '0; tvs_channel = '0; tvs_valid = 1'b0; tvs_active = 1'b0;
        tvs_temp_high = 1'b0; tvs_temp_low = 1'b0; enable_mask = '0;
        minmax_clr = 1'b0; alarm_clr = 1'b0; rd_req = 1'b0; rd_ch = '0; rd_sel = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;

        tvs_active = 1'b1;
        repeat (4) @(negedge clk);
        chk("sensor_active", 32'(sensor_active), 1);

        // masked-off channel discards the sample but restarts the timer
        set_mask(4'h7);
        pulse(3, 'h2000, 0, 0, 0);
        chk("masked_stale", 32'(stale), 0);
        read_check("masked_cnt", 3, 3, 32'h0);
        read_check("masked_min", 3, 1, 32'hFFFF);

        set_mask(4'hF);
        pulse(3, 'h1200, 0, 0, 0);
        pulse(3, 'h1100, 0, 0, 0);
        pulse(3, 'h1300, 0, 0, 0);
        read_check("ch3_last", 3, 0, 32'h1300);
        read_check("ch3_min",  3, 1, 32'h1100);
        read_check("ch3_max",  3, 2, 32'h1300);
        read_check("ch3_cnt",  3, 3, 32'h3);

        pulse(0, 'h0400, 1, 0, 0);
        read_check("clrcap_min", 0, 1, 32'h0400);
        read_check("clrcap_max", 0, 2, 32'h0400);
        read_check("clrcap_cnt", 0, 3, 32'h1);
        read_check("clrcap_ch3_cnt", 3, 3, 32'h0);
        read_check("clrcap_ch3_last", 3, 0, 32'h1300);

        // read on the capture cycle sees the old value
        pulse(0, 'h0500, 0, 1, 0);
        read_check("post_coinc_last", 0, 0, 32'h0500);

        @(negedge clk);
        rd_req = 1'b1; rd_ch = 2'd3; rd_sel = 2'd0;
        @(negedge clk);
        rd_ch = 2'd0; rd_sel = 2'd3;
        chk("b2b_ack0", 32'(rd_ack), 1);
        chk("b2b_data0", 32'(rd_data), m_field(3, 0));
        @(negedge clk);
        rd_req = 1'b0;
        chk("b2b_ack1", 32'(rd_ack), 1);
        chk("b2b_data1", 32'(rd_data), m_field(0, 3));
        @(negedge clk);
        chk("b2b_ack_off", 32'(rd_ack), 0);
        chk("b2b_hold", 32'(rd_data), m_field(0, 3));

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) set_mask(4'($urandom));
            ch  = int'($urandom_range(0, 3));
            val = int'($urandom_range(0, 'hFFFF));
            if ($urandom_range(0, 5) == 0) val = ($urandom_range(0, 1) == 1) ? 'hFFFF : 0;
            clr = ($urandom_range(0, 7) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            sel = int'($urandom_range(0, 3));
            pulse(ch, val, clr, rd, sel);
            rch  = int'($urandom_range(0, 3));
            rsel = int'($urandom_range(0, 3));
            read_check("rand", rch, rsel, m_field(rch, rsel));
        end

        set_mask(4'hF);
        pulse(1, 'h0123, 0, 0, 0);
        repeat (11) @(negedge clk);
        chk("stale_before", 32'(stale), 0);
        @(negedge clk);
        chk("stale_at_limit", 32'(stale), 1);
        repeat (5) @(negedge clk);
        chk("stale_saturated", 32'(stale), 1);
        pulse(1, 'h0124, 0, 0, 0);
        chk("stale_cleared", 32'(stale), 0);

        tvs_temp_high = 1'b1;
        repeat (4) @(negedge clk);
        chk("alarm_high_set", 32'(alarm_high), 1);
        chk("alarm_low_quiet", 32'(alarm_low), 0);
        alarm_clr = 1'b1;
        @(negedge clk);
        alarm_clr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            clr_h[i] = tvs_temp_high_clear;
            clr_l[i] = tvs_temp_low_clear;
            alm[i]   = alarm_high;
            alarm_clr = (i == 1);   // request during PULSE must be ignored
            @(negedge clk);
        end
        alarm_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("clr_high_%0d", i), 32'(clr_h[i]), 32'(i < CLR_CYC));
            chk($sformatf("clr_low_%0d", i), 32'(clr_l[i]), 32'(i < CLR_CYC));
        end
        for (int i = 0; i < CLR_CYC + 3; i++)
            chk($sformatf("alarm_inhibit_%0d", i), 32'(alm[i]), 0);
        chk("alarm_reassert", 32'(alm[CLR_CYC + 4]), 1);

        tvs_temp_high = 1'b0;
        repeat (4) @(negedge clk);
        alarm_clr = 1'b1;
        @(negedge clk);
        alarm_clr = 1'b0;
        repeat (12) @(negedge clk);
        chk("alarm_high_stays_clear", 32'(alarm_high), 0);

        tvs_temp_low = 1'b1;
        repeat (4) @(negedge clk);
        chk("alarm_low_set", 32'(alarm_low), 1);
        tvs_temp_low = 1'b0;

        // reset hits mid-PULSE with a read in flight
        alarm_clr = 1'b1;
        @(negedge clk);
        alarm_clr = 1'b0;
        @(negedge clk);
        chk("pulse_active", 32'(tvs_temp_high_clear), 1);
        rd_req = 1'b1; rd_ch = 2'd1; rd_sel = 2'd0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        rd_req = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("no_ack_after_rst_%0d", i), 32'(rd_ack), 0);
        end
        read_check("rst_last", 1, 0, m_field(1, 0));
        read_check("rst_min", 3, 1, m_field(3, 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
